lsu_pipe_arbiter: RTL and testbench
===================================

Name: lsu_pipe_arbiter

Overview:
Sequences the single LSU ID->EX pipeline slot between four requesters: MHQ cache fill, store-queue retire, load-queue replay and new FU issue. The base priority order is fixed, and starvation counters temporarily boost load replays and new issues. The block sits in front of the ID->EX pipeline register in the LSU. It drives the mux select, the per-requester grants and the stall signals that go back to the SQ, the LQ and the reservation station.

Parameters:
- STARVE_LIMIT, 8: consecutive denied-but-eligible cycles before a requester is boosted; legal range 1..255.
- PERF_WIDTH, 32: width of each performance counter (used only with the optional feature).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous reset, active-low
- i_flush  in  1  pipeline flush
- i_ex_stall  in  1  downstream cannot accept this cycle; no grant is issued
- i_fill_req  in  1  MHQ fill request
- i_sq_req  in  1  SQ retire request
- i_lq_req  in  1  LQ replay request
- i_fu_req  in  1  FU issue valid
- o_fill_gnt  out  1  fill granted
- o_sq_gnt  out  1  SQ retire granted
- o_lq_gnt  out  1  LQ replay granted
- o_fu_gnt  out  1  FU issue granted
- o_sel  out  2  encoded mux select: 0=FU, 1=LQ, 2=SQ, 3=FILL
- o_id_valid  out  1  the ID->EX slot is loaded this cycle
- o_sq_stall  out  1  SQ must hold its retire head
- o_lq_stall  out  1  LQ must hold its replay entry
- o_fu_stall  out  1  reservation station must not issue
- o_perf_fill, o_perf_sq, o_perf_lq, o_perf_fu  out  PERF_WIDTH  grant counts (optional feature)

Behaviour:
- Grants are combinational from the requests and the registered state; zero-cycle latency. At most one grant is asserted per cycle.
- No grant is issued when i_flush or i_ex_stall is high; in that case every requesting input sees its stall asserted.
- o_id_valid is the OR of all grants. o_sel follows the winner and is 0 when there is no grant.
- A stall is asserted for requester X when X requests and is not granted.
- o_fu_stall is additionally asserted whenever i_fill_req is high, even if i_fu_req is low.
- FSM state is a 2-bit value, reset to ARB_NORMAL:
  - ARB_NORMAL priority: FILL > SQ > LQ > FU.
  - ARB_LQ_BOOST priority: FILL > LQ > SQ > FU.
  - ARB_FU_BOOST priority: FILL > FU > SQ > LQ.
- Fill always wins in every state; a fill is never boosted past.
- Starvation counters exist for LQ and FU, each $clog2(STARVE_LIMIT+1) bits wide, reset to 0.
  - Increment: the requester requests, is not granted, and there is no flush, no i_ex_stall and no i_fill_req.
  - Hold: during fill cycles or i_ex_stall cycles.
  - Clear: on grant, or when the requester deasserts its request.
  - Saturate at STARVE_LIMIT.
- FSM transitions, registered:
  - NORMAL -> LQ_BOOST when cnt_lq == STARVE_LIMIT.
  - Otherwise NORMAL -> FU_BOOST when cnt_fu == STARVE_LIMIT. If both are saturated, LQ is boosted first.
  - LQ_BOOST -> NORMAL when o_lq_gnt, or when i_lq_req drops.
  - FU_BOOST -> NORMAL when o_fu_gnt, or when i_fu_req drops.
  - A requester whose counter is already saturated is boosted on the next NORMAL evaluation, so alternating boosts are possible.
- i_flush, registered effect:
  - Clears both counters and returns the state to ARB_NORMAL.
  - Grants are 0 in the flush cycle.
- Reset value of every output: all grants 0, o_sel 0, o_id_valid 0, perf counters 0.
  - Stalls are combinational from the requests. With all requests low they reset to 0, except o_fu_stall, which follows i_fill_req.
- Asserting reset in the middle of a boost returns the block to ARB_NORMAL with both counters cleared.

Optional Feature:
- LSU_ARB_PERF_EN defined:
  - Four saturating PERF_WIDTH-bit counters, each incrementing on its grant.
  - Cleared by reset only; flush does not clear them.
- LSU_ARB_PERF_EN undefined: the o_perf_* ports are driven constant 0 and no counter flops are built.

Decomposition:
- procyon_types gains:
  - lsu_arb_sel_t enum: ARB_SEL_FU, ARB_SEL_LQ, ARB_SEL_SQ, ARB_SEL_FILL.
  - lsu_arb_state_t enum: ARB_NORMAL, ARB_LQ_BOOST, ARB_FU_BOOST.
- Sub-module lsu_arb_starve_cnt: a parameterised saturating counter with inc, hold and clear inputs and a sat output. It is instantiated twice, once for LQ and once for FU.

Test Plan:
- All four requests high for 1 cycle -> o_fill_gnt=1, o_sel=3, o_fu_stall=o_sq_stall=o_lq_stall=1.
- With STARVE_LIMIT=4, i_sq_req and i_lq_req held high continuously:
  - The SQ is granted in cycles 0-3, cnt_lq reaches 4, and the state becomes LQ_BOOST.
  - Cycle 4: o_lq_gnt=1 and o_sel=1.
  - Cycle 5: back to NORMAL, and the SQ is granted.
- With STARVE_LIMIT=4, i_sq_req, i_lq_req and i_fu_req all held high continuously:
  - The LQ boost fires first.
  - After its grant the FU counter is still saturated, so FU_BOOST is entered and o_fu_gnt=1 two cycles after the LQ boost grant.
- In LQ_BOOST, assert i_fill_req for 3 cycles -> the fill is granted for 3 cycles, the counters hold, and the LQ is granted on the following cycle.
- While cnt_lq=3, with SQ and LQ requesting:
  - Pulse i_ex_stall for 2 cycles -> no grants and cnt_lq stays at 3.
  - Then pulse i_flush -> grants are 0, cnt_lq=0, the state is NORMAL, and the next cycle grants the SQ.
- With LSU_ARB_PERF_EN defined, run 10 SQ grants and 3 LQ grants -> o_perf_sq=10 and o_perf_lq=3. Then flush -> the values are unchanged. Then n_rst -> all counters read 0.

Source files
------------

// File: rtl/lsu_pipe_arbiter_pkg.sv
// Shared types for the LSU ID->EX slot arbiter: mux select encoding and arbitration states.
package lsu_pipe_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_SEL_FU   = 2'd0,
      ARB_SEL_LQ   = 2'd1,
      ARB_SEL_SQ   = 2'd2,
      ARB_SEL_FILL = 2'd3
   } lsu_arb_sel_t;

   typedef enum logic [1:0] {
      ARB_NORMAL   = 2'd0,
      ARB_LQ_BOOST = 2'd1,
      ARB_FU_BOOST = 2'd2
   } lsu_arb_state_t;

   // Bit positions of the one-hot grant vector line up with the select encoding.
   function automatic logic [3:0] sel_onehot(input lsu_arb_sel_t sel);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/lsu_arb_starve_cnt.sv
// Saturating starvation counter; sat reports the value the counter will hold after this cycle.
module lsu_arb_starve_cnt #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic n_rst,
   input  logic inc,
   input  logic hold,
   input  logic clear,
   output logic sat
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!hold && inc && (cnt_q != LIMIT_V)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Looking at the next value lets the boost take effect the cycle after saturation.
   assign sat = (cnt_d == LIMIT_V);

endmodule

// File: rtl/lsu_pipe_arbiter.sv
// Arbitrates the LSU ID->EX slot between fill, SQ retire, LQ replay and FU issue with starvation boosts.
// Optional grant performance counters are built when LSU_ARB_PERF_EN is defined.
module lsu_pipe_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int PERF_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_flush,
   input  logic                  i_ex_stall,
   input  logic                  i_fill_req,
   input  logic                  i_sq_req,
   input  logic                  i_lq_req,
   input  logic                  i_fu_req,
   output logic                  o_fill_gnt,
   output logic                  o_sq_gnt,
   output logic                  o_lq_gnt,
   output logic                  o_fu_gnt,
   output logic [1:0]            o_sel,
   output logic                  o_id_valid,
   output logic                  o_sq_stall,
   output logic                  o_lq_stall,
   output logic                  o_fu_stall,
   output logic [PERF_WIDTH-1:0] o_perf_fill,
   output logic [PERF_WIDTH-1:0] o_perf_sq,
   output logic [PERF_WIDTH-1:0] o_perf_lq,
   output logic [PERF_WIDTH-1:0] o_perf_fu
);

   import lsu_pipe_arbiter_pkg::*;

   lsu_arb_state_t state_q;
   lsu_arb_state_t state_d;
   lsu_arb_sel_t   win_sel;
   logic           win_valid;
   logic [3:0]     gnt_vec;
   logic           lq_sat;
   logic           fu_sat;
   logic           arb_blocked;

   assign arb_blocked = i_flush | i_ex_stall;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ARB_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ARB_NORMAL;
      end else begin
         case (state_q)
            ARB_NORMAL: begin
               if (lq_sat) begin
                  state_d = ARB_LQ_BOOST;
               end else if (fu_sat) begin
                  state_d = ARB_FU_BOOST;
               end
            end
            ARB_LQ_BOOST: begin
               if (o_lq_gnt || !i_lq_req) begin
                  state_d = ARB_NORMAL;
               end
            end
            ARB_FU_BOOST: begin
               if (o_fu_gnt || !i_fu_req) begin
                  state_d = ARB_NORMAL;
               end
            end
            default: state_d = ARB_NORMAL;
         endcase
      end
   end

   // Fill always wins; the state only reorders SQ, LQ and FU behind it.
   always_comb begin
      win_valid = 1'b0;
      win_sel   = ARB_SEL_FU;
      if (!arb_blocked) begin
         win_valid = 1'b1;
         if (i_fill_req) begin
            win_sel = ARB_SEL_FILL;
         end else begin
            case (state_q)
               ARB_LQ_BOOST: begin
                  if (i_lq_req)      win_sel = ARB_SEL_LQ;
                  else if (i_sq_req) win_sel = ARB_SEL_SQ;
                  else if (i_fu_req) win_sel = ARB_SEL_FU;
                  else               win_valid = 1'b0;
               end
               ARB_FU_BOOST: begin
                  if (i_fu_req)      win_sel = ARB_SEL_FU;
                  else if (i_sq_req) win_sel = ARB_SEL_SQ;
                  else if (i_lq_req) win_sel = ARB_SEL_LQ;
                  else               win_valid = 1'b0;
               end
               default: begin
                  if (i_sq_req)      win_sel = ARB_SEL_SQ;
                  else if (i_lq_req) win_sel = ARB_SEL_LQ;
                  else if (i_fu_req) win_sel = ARB_SEL_FU;
                  else               win_valid = 1'b0;
               end
            endcase
         end
      end
   end

   assign gnt_vec    = win_valid ? sel_onehot(win_sel) : 4'b0000;
   assign o_fill_gnt = gnt_vec[ARB_SEL_FILL];
   assign o_sq_gnt   = gnt_vec[ARB_SEL_SQ];
   assign o_lq_gnt   = gnt_vec[ARB_SEL_LQ];
   assign o_fu_gnt   = gnt_vec[ARB_SEL_FU];
   assign o_sel      = win_valid ? win_sel : ARB_SEL_FU;
   assign o_id_valid = |gnt_vec;

   // A pending fill needs the reservation station quiet even when it has nothing to issue.
   assign o_sq_stall = i_sq_req & ~o_sq_gnt;
   assign o_lq_stall = i_lq_req & ~o_lq_gnt;
   assign o_fu_stall = (i_fu_req & ~o_fu_gnt) | i_fill_req;

   lsu_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_lq_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .inc   (i_lq_req & ~o_lq_gnt),
      .hold  (i_ex_stall | i_fill_req),
      .clear (i_flush | ~i_lq_req | o_lq_gnt),
      .sat   (lq_sat)
   );

   lsu_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_fu_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .inc   (i_fu_req & ~o_fu_gnt),
      .hold  (i_ex_stall | i_fill_req),
      .clear (i_flush | ~i_fu_req | o_fu_gnt),
      .sat   (fu_sat)
   );

`ifdef LSU_ARB_PERF_EN
   logic [3:0][PERF_WIDTH-1:0] perf_q;

   // Grant counts survive a flush; only reset clears them.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         perf_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (gnt_vec[i] && (perf_q[i] != {PERF_WIDTH{1'b1}})) begin
               perf_q[i] <= perf_q[i] + PERF_WIDTH'(1);
            end
         end
      end
   end

   assign o_perf_fill = perf_q[ARB_SEL_FILL];
   assign o_perf_sq   = perf_q[ARB_SEL_SQ];
   assign o_perf_lq   = perf_q[ARB_SEL_LQ];
   assign o_perf_fu   = perf_q[ARB_SEL_FU];
`else
   assign o_perf_fill = '0;
   assign o_perf_sq   = '0;
   assign o_perf_lq   = '0;
   assign o_perf_fu   = '0;
`endif

endmodule

// File: tb/tb_lsu_pipe_arbiter.sv
// Directed self-checking bench for lsu_pipe_arbiter with STARVE_LIMIT=4.
module tb_lsu_pipe_arbiter;

   localparam int LIMIT = 4;
   localparam int PW    = 32;

   localparam logic [3:0] G_NONE = 4'b0000;
   localparam logic [3:0] G_FILL = 4'b1000;
   localparam logic [3:0] G_SQ   = 4'b0100;
   localparam logic [3:0] G_LQ   = 4'b0010;
   localparam logic [3:0] G_FU   = 4'b0001;

`ifdef LSU_ARB_PERF_EN
   localparam int EXP_PERF_SQ = 10;
   localparam int EXP_PERF_LQ = 3;
`else
   localparam int EXP_PERF_SQ = 0;
   localparam int EXP_PERF_LQ = 0;
`endif

   logic          clk = 1'b0;
   logic          n_rst;
   logic          i_flush, i_ex_stall, i_fill_req, i_sq_req, i_lq_req, i_fu_req;
   logic          o_fill_gnt, o_sq_gnt, o_lq_gnt, o_fu_gnt;
   logic [1:0]    o_sel;
   logic          o_id_valid, o_sq_stall, o_lq_stall, o_fu_stall;
   logic [PW-1:0] o_perf_fill, o_perf_sq, o_perf_lq, o_perf_fu;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_pipe_arbiter #(.STARVE_LIMIT(LIMIT), .PERF_WIDTH(PW)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_flush     (i_flush),
      .i_ex_stall  (i_ex_stall),
      .i_fill_req  (i_fill_req),
      .i_sq_req    (i_sq_req),
      .i_lq_req    (i_lq_req),
      .i_fu_req    (i_fu_req),
      .o_fill_gnt  (o_fill_gnt),
      .o_sq_gnt    (o_sq_gnt),
      .o_lq_gnt    (o_lq_gnt),
      .o_fu_gnt    (o_fu_gnt),
      .o_sel       (o_sel),
      .o_id_valid  (o_id_valid),
      .o_sq_stall  (o_sq_stall),
      .o_lq_stall  (o_lq_stall),
      .o_fu_stall  (o_fu_stall),
      .o_perf_fill (o_perf_fill),
      .o_perf_sq   (o_perf_sq),
      .o_perf_lq   (o_perf_lq),
      .o_perf_fu   (o_perf_fu)
   );

   task automatic applyStimulus(input logic fill, input logic sq, input logic lq,
                                input logic fu, input logic flush, input logic exs);
      i_fill_req = fill;
      i_sq_req   = sq;
      i_lq_req   = lq;
      i_fu_req   = fu;
      i_flush    = flush;
      i_ex_stall = exs;
   endtask

   // Expected vector layout: {fill,sq,lq,fu grants, sel, id_valid, sq/lq/fu stalls}.
   task automatic checkNow(input string tag, input logic [3:0] gnt_exp,
                           input logic [1:0] sel_exp, input logic [2:0] stall_exp);
      logic [9:0] obs;
      logic [9:0] exp;
      obs = {o_fill_gnt, o_sq_gnt, o_lq_gnt, o_fu_gnt, o_sel, o_id_valid,
             o_sq_stall, o_lq_stall, o_fu_stall};
      exp = {gnt_exp, sel_exp, |gnt_exp, stall_exp};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] gnt_exp,
                              input logic [1:0] sel_exp, input logic [2:0] stall_exp);
      @(negedge clk);
      checkNow(tag, gnt_exp, sel_exp, stall_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic checkPerf(input string tag, input int fill, input int sq,
                            input int lq, input int fu);
      logic [4*PW-1:0] obs;
      logic [4*PW-1:0] exp;
      obs = {o_perf_fill, o_perf_sq, o_perf_lq, o_perf_fu};
      exp = {PW'(fill), PW'(sq), PW'(lq), PW'(fu)};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      n_rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      #12;
      checkNow("reset_idle", G_NONE, 2'd0, 3'b000);
      checkPerf("reset_perf", 0, 0, 0, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] fixed priority and fill stall");
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput("all_req_fill_wins", G_FILL, 2'd3, 3'b111);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("fill_only_fu_stall", G_FILL, 2'd3, 3'b001);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("fu_only_sel0", G_FU, 2'd0, 3'b000);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_a", G_NONE, 2'd0, 3'b000);

      $display("[TB] LQ starvation boost");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("lqs_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      checkOutput("lqs_boost_lq", G_LQ, 2'd1, 3'b100);
      checkOutput("lqs_back_sq", G_SQ, 2'd2, 3'b010);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_b", G_NONE, 2'd0, 3'b000);

      $display("[TB] alternating LQ then FU boost");
      applyStimulus(0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("alt_sq_%0d", i), G_SQ, 2'd2, 3'b011);
      checkOutput("alt_lq_boost", G_LQ, 2'd1, 3'b101);
      checkOutput("alt_sq_mid", G_SQ, 2'd2, 3'b011);
      checkOutput("alt_fu_boost", G_FU, 2'd0, 3'b110);
      checkOutput("alt_sq_after", G_SQ, 2'd2, 3'b011);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_c", G_NONE, 2'd0, 3'b000);

      $display("[TB] fill during LQ boost");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("fb_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      applyStimulus(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("fb_fill_%0d", i), G_FILL, 2'd3, 3'b111);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("fb_lq_after_fill", G_LQ, 2'd1, 3'b100);
      checkOutput("fb_sq_normal", G_SQ, 2'd2, 3'b010);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_d", G_NONE, 2'd0, 3'b000);

      $display("[TB] ex_stall holds the starvation count");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("hs_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      applyStimulus(0, 1, 1, 0, 0, 1);
      checkOutput("hs_stall", G_NONE, 2'd0, 3'b110);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("hs_sq_fourth", G_SQ, 2'd2, 3'b010);
      checkOutput("hs_lq_boost", G_LQ, 2'd1, 3'b100);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_e", G_NONE, 2'd0, 3'b000);

      $display("[TB] ex_stall then flush clears the count");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("fl_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      applyStimulus(0, 1, 1, 0, 0, 1);
      checkOutput("fl_stall_0", G_NONE, 2'd0, 3'b110);
      checkOutput("fl_stall_1", G_NONE, 2'd0, 3'b110);
      applyStimulus(0, 1, 1, 0, 1, 0);
      checkOutput("fl_flush", G_NONE, 2'd0, 3'b110);
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("fl_post_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      checkOutput("fl_post_lq", G_LQ, 2'd1, 3'b100);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_f", G_NONE, 2'd0, 3'b000);

      $display("[TB] flush during LQ boost");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("fbst_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      applyStimulus(0, 1, 1, 0, 1, 0);
      checkOutput("fbst_flush", G_NONE, 2'd0, 3'b110);
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("fbst_post_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      checkOutput("fbst_post_lq", G_LQ, 2'd1, 3'b100);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_g", G_NONE, 2'd0, 3'b000);

      $display("[TB] reset during LQ boost");
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("rb_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      n_rst = 1'b0;
      #3;
      n_rst = 1'b1;
      for (int i = 0; i < 4; i++) checkOutput($sformatf("rb_post_sq_%0d", i), G_SQ, 2'd2, 3'b010);
      checkOutput("rb_post_lq", G_LQ, 2'd1, 3'b100);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_h", G_NONE, 2'd0, 3'b000);

      $display("[TB] performance counters");
      n_rst = 1'b0;
      #2;
      n_rst = 1'b1;
      applyStimulus(0, 1, 1, 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) checkOutput($sformatf("pf_sq_%0d_%0d", r, i), G_SQ, 2'd2, 3'b010);
         checkOutput($sformatf("pf_lq_%0d", r), G_LQ, 2'd1, 3'b100);
      end
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("pf_sq_solo_a", G_SQ, 2'd2, 3'b000);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("pf_lq_solo", G_LQ, 2'd1, 3'b000);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("pf_sq_solo_b", G_SQ, 2'd2, 3'b000);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkPerf("perf_counts", 0, EXP_PERF_SQ, EXP_PERF_LQ, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("pf_flush", G_NONE, 2'd0, 3'b000);
      checkPerf("perf_after_flush", 0, EXP_PERF_SQ, EXP_PERF_LQ, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      n_rst = 1'b0;
      #1;
      checkPerf("perf_after_reset", 0, 0, 0, 0);
      n_rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
